compdiv_seq: RTL and testbench

COMPDIV_SEQ -- requirements
Module: compdiv_seq

---
 rtl/compdiv_seq.sv | 175 +++++++++++++++++
 tb/tb_compdiv_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/compdiv_seq.sv
// compdiv_seq -- sequential fixed-point complex divider, q = a / b.
//
// The quotient carries F = N-1 fractional bits. The numerators and the shared
// denominator are formed in one cycle. Both quotient parts are then produced by
// restoring division, one bit per cycle, with the two parts in parallel.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   start        begin a division (sampled only in IDLE)
//   a_r, a_i     signed dividend (N bits each)
//   b_r, b_i     signed divisor  (N bits each)
//   busy         operation in progress
//   done         one-cycle pulse, results valid
//   q_r, q_i     signed quotient, 2N bits, F fractional bits
//   div_by_zero  set with done when b = 0
//
// state | meaning
// IDLE  | waiting for start; operands are captured on accept
// MULT  | form nr, ni, den and the signs; load the dividends and the counter
// DIV   | one restoring-division iteration per cycle, W cycles
// FIX   | apply the signs, update the outputs, pulse done

module compdiv_seq #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [N-1:0]   a_r,
  input  logic signed [N-1:0]   a_i,
  input  logic signed [N-1:0]   b_r,
  input  logic signed [N-1:0]   b_i,
  output logic                  busy,
  output logic                  done,
  output logic signed [2*N-1:0] q_r,
  output logic signed [2*N-1:0] q_i,
  output logic                  div_by_zero
);

  localparam int F  = N - 1;
  localparam int PW = 2 * N + 1;     // product / sum width
  localparam int W  = PW + F;        // dividend width = iteration count (3N)
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

  state_t state, state_nxt;

  logic signed [N-1:0] ar_q, ai_q, br_q, bi_q;
  logic [PW-1:0]       den;
  logic                sgn_r, sgn_i;
  logic [W-1:0]        dvd_r, dvd_i;   // dividend shifts out, quotient shifts in
  logic [PW-1:0]       rem_r, rem_i;
  logic [CW-1:0]       cnt;

  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0] nr, ni;
  logic [PW-1:0]        den_c, nr_mag, ni_mag;
  logic [PW:0]          rsh_r, rsh_i;
  logic                 ge_r, ge_i;
  logic [PW-1:0]        rem_r_nxt, rem_i_nxt;
  logic [2*N-1:0]       qm_r, qm_i;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = MULT;
      MULT: state_nxt = DIV;
      DIV:  if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------- arithmetic
  always_comb begin
    ar_x   = PW'(ar_q);
    ai_x   = PW'(ai_q);
    br_x   = PW'(br_q);
    bi_x   = PW'(bi_q);
    nr     = ar_x * br_x + ai_x * bi_x;
    ni     = ai_x * br_x - ar_x * bi_x;
    den_c  = $unsigned(br_x * br_x + bi_x * bi_x);
    nr_mag = nr[PW-1] ? $unsigned(-nr) : $unsigned(nr);
    ni_mag = ni[PW-1] ? $unsigned(-ni) : $unsigned(ni);
  end

  // The remainder stays below den, so one extra bit holds the shifted value.
  always_comb begin
    rsh_r     = {rem_r, dvd_r[W-1]};
    rsh_i     = {rem_i, dvd_i[W-1]};
    ge_r      = (rsh_r >= {1'b0, den});
    ge_i      = (rsh_i >= {1'b0, den});
    rem_r_nxt = PW'(ge_r ? rsh_r - {1'b0, den} : rsh_r);
    rem_i_nxt = PW'(ge_i ? rsh_i - {1'b0, den} : rsh_i);
    // The quotient magnitude is bounded below 2^(2N-1), so the low 2N bits suffice.
    qm_r      = dvd_r[2*N-1:0];
    qm_i      = dvd_i[2*N-1:0];
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ar_q        <= '0;
      ai_q        <= '0;
      br_q        <= '0;
      bi_q        <= '0;
      den         <= '0;
      sgn_r       <= 1'b0;
      sgn_i       <= 1'b0;
      dvd_r       <= '0;
      dvd_i       <= '0;
      rem_r       <= '0;
      rem_i       <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      q_r         <= '0;
      q_i         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ar_q <= a_r;
            ai_q <= a_i;
            br_q <= b_r;
            bi_q <= b_i;
          end
        end
        MULT: begin
          den   <= den_c;
          sgn_r <= nr[PW-1];
          sgn_i <= ni[PW-1];
          dvd_r <= {nr_mag, {F{1'b0}}};
          dvd_i <= {ni_mag, {F{1'b0}}};
          rem_r <= '0;
          rem_i <= '0;
          cnt   <= CW'(W - 1);
        end
        DIV: begin
          dvd_r <= {dvd_r[W-2:0], ge_r};
          dvd_i <= {dvd_i[W-2:0], ge_i};
          rem_r <= rem_r_nxt;
          rem_i <= rem_i_nxt;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (den == '0) begin
            // Divide ran with den = 0 and produced all ones; discard it.
            q_r         <= '0;
            q_i         <= '0;
            div_by_zero <= 1'b1;
          end else begin
            q_r         <= sgn_r ? -qm_r : qm_r;
            q_i         <= sgn_i ? -qm_i : qm_i;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compdiv_seq.sv
// tb_compdiv_seq -- scoreboard bench for compdiv_seq (N = 8).
// Stimulus pushes the hand-computed result and the edge on which done is due;
// a monitor pops and compares on every done pulse.

module tb_compdiv_seq;

  localparam int N   = 8;
  localparam int LAT = 26;   // accept edge to done edge, W + 2 with W = 3N

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic signed [N-1:0]   a_r = '0, a_i = '0, b_r = '0, b_i = '0;
  logic                  busy, done, div_by_zero;
  logic signed [2*N-1:0] q_r, q_i;

  compdiv_seq #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a_r         (a_r),
    .a_i         (a_i),
    .b_r         (b_r),
    .b_i         (b_i),
    .busy        (busy),
    .done        (done),
    .q_r         (q_r),
    .q_i         (q_i),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int qr;
    int qi;
    int dbz;
    int due;
  } exp_t;

  typedef struct {
    int ar, ai, br, bi;
    int qr, qi, dbz;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  int   last_accept = 0;

  task automatic chk(input string name, input longint act, input longint want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset && done) begin
      int   mag;
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done_pending", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("q_r", q_r, e.qr);
        chk("q_i", q_i, e.qi);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("done_latency", cyc, e.due);
        mag = (q_r < 0) ? -int'(q_r) : int'(q_r);
        if (int'(q_i) < 0 && -int'(q_i) > mag) mag = -int'(q_i);
        else if (int'(q_i) > mag) mag = int'(q_i);
        chk("q_within_bound", (mag <= 23170), 1);
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; returns at the negedge after accept.
  task automatic issue(input vec_t v);
    exp_t e;
    a_r   = 8'(v.ar);
    a_i   = 8'(v.ai);
    b_r   = 8'(v.br);
    b_i   = 8'(v.bi);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_r   = 8'($urandom);
    a_i   = 8'($urandom);
    b_r   = 8'($urandom);
    b_i   = 8'($urandom);
    last_accept = cyc;
    e.qr  = v.qr;
    e.qi  = v.qi;
    e.dbz = v.dbz;
    e.due = cyc + LAT;
    exp_q.push_back(e);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout_busy", busy, 0);
  endtask

  function automatic vec_t mk(input int ar, ai, br, bi, qr, qi, dbz);
    vec_t v;
    v.ar = ar; v.ai = ai; v.br = br; v.bi = bi;
    v.qr = qr; v.qi = qi; v.dbz = dbz;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int saved_done;

    vecs.push_back(mk(  64,    0,   64,    0,    128,      0, 0));
    vecs.push_back(mk(   3,    4,    1,    2,    281,    -51, 0));
    vecs.push_back(mk(-128, -128,    1,    0, -16384, -16384, 0));
    vecs.push_back(mk(   0,   64,   64,    0,      0,    128, 0));
    vecs.push_back(mk(   5,    5,    0,    0,      0,      0, 1));
    vecs.push_back(mk(-128, -128, -128, -128,    128,      0, 0));
    vecs.push_back(mk( 127, -128,    0,    1, -16384, -16256, 0));
    vecs.push_back(mk(   1,    0,  127,  127,      0,      0, 0));
    vecs.push_back(mk(   7,   -3,    2,   -1,    435,     25, 0));
    vecs.push_back(mk(  -5,    3,   -2,    0,    320,   -192, 0));

    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q_r", q_r, 0);
    chk("rst_q_i", q_i, 0);
    chk("rst_dbz", div_by_zero, 0);

    // release and start together: accepted on the first rising edge
    reset = 1'b1;
    foreach (vecs[i]) begin
      wait_idle();
      issue(vecs[i]);
    end
    wait_idle();

    // start pulsed while busy is ignored; start with done accepted back-to-back
    issue(vecs[0]);
    k = last_accept;
    repeat (4) @(negedge clk);
    a_r = 8'sd1; a_i = 8'sd1; b_r = 8'sd1; b_i = 8'sd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_ignored_start", busy, 1);
    wait_idle();
    chk("first_done_edge", cyc, k + LAT);
    chk("done_high_when_idle", done, 1);
    issue(vecs[1]);
    chk("b2b_accept_edge", last_accept, k + LAT + 1);
    wait_idle();

    // reset mid-operation aborts without a done pulse
    issue(vecs[2]);
    k = last_accept;
    repeat (10) @(negedge clk);
    saved_done = n_done;
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q_r", q_r, 0);
    chk("abort_q_i", q_i, 0);
    chk("abort_dbz", div_by_zero, 0);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", n_done, saved_done);

    issue(vecs[8]);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
